frame_buffer_writer: RTL and testbench
======================================

Name: frame_buffer_writer

Overview:
- Write-side counterpart to the external image memory reader.
- Accepts processed pixels two at a time (pix_in1/pix_in2, matching the reader's dual-pixel output) over a valid/ready handshake.
- Serialises each pair into single-port memory writes at linear raster addresses 0..IMG_W*IMG_H-1.
- Sits at the tail of the image-processing pipeline and stores one full output frame per start command.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 256: image width in pixels; IMG_W*IMG_H must be even.
- IMG_H, 256: image height in lines.
- ADDR_W, 16: memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin writing a frame; honoured only in IDLE.
- pix_in1  in  DATA_W  first (even-address) pixel of the pair.
- pix_in2  in  DATA_W  second (odd-address) pixel of the pair.
- pix_valid  in  1  pixel pair present on pix_in1/pix_in2.
- pix_ready  out  1  writer can capture a pair this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- busy  out  1  frame write in progress.
- done  out  1  one-cycle pulse after the last pixel is written.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, address counter 0, pair registers 0.
- All outputs are decoded from flops only; no input-to-output combinational path.
- A transfer occurs on any rising edge where pix_valid && pix_ready; pix_in1 and pix_in2 are captured together.
- States:
  - IDLE: pix_ready=0, busy=0. start=1 -> ACCEPT; address counter cleared to 0.
  - ACCEPT: pix_ready=1, busy=1, mem_we=0. On transfer -> WR1.
  - WR1: mem_we=1, mem_addr=addr_cnt, mem_wdata=pair reg 1, pix_ready=0. addr_cnt++ -> WR2.
  - WR2: mem_we=1, mem_addr=addr_cnt, mem_wdata=pair reg 2. addr_cnt++.
    - If addr_cnt == IMG_W*IMG_H-1: pix_ready=0 -> FIN.
    - Else pix_ready=1: transfer -> WR1 (back-to-back capture); no transfer -> ACCEPT.
  - FIN: done=1, busy=1, mem_we=0 -> IDLE. done is high for exactly this one cycle.
- Latency:
  - Write of pix_in1 appears the cycle after capture; write of pix_in2 the cycle after that.
  - Peak throughput is one pair per 2 cycles; mem_we stays high continuously while valid is held.
- Outside WR1/WR2: mem_we=0, and mem_addr/mem_wdata hold their last values.
- Boundary conditions:
  - start while busy: ignored, no effect.
  - start coincident with done (FIN): ignored; a new start is accepted from IDLE onward.
  - pix_valid high while pix_ready=0: no capture; the source must hold its data.
  - pix_valid in IDLE: ignored.
  - Address counter never wraps within a frame. The final write is at IMG_W*IMG_H-1, and the counter is cleared by the next start.
  - rst_n asserted mid-frame: immediate return to IDLE with all outputs 0; the partial frame is abandoned and the next start begins at address 0.

Decomposition:
- Shared package img_pkg:
  - state enum {IDLE, ACCEPT, WR1, WR2, FIN};
  - default DATA_W;
  - localparam function computing FRAME_PIX = IMG_W*IMG_H.
- Single module: FSM, address counter, two pair registers. No sub-module is warranted; the address counter stays inline.

Test Plan:
All scenarios use IMG_W=4, IMG_H=2 (FRAME_PIX=8) unless noted.
- Reset: hold rst_n=0 with random inputs -> pix_ready, mem_we, mem_addr, mem_wdata, busy, done all 0; rst_n released with no start -> state stays IDLE, busy=0.
- Back-to-back frame: start pulse; pix_valid held 1 with pairs (0x10,0x11),(0x20,0x21),(0x30,0x31),(0x40,0x41) -> mem_we high 8 consecutive cycles, addr 0..7, data 10,11,20,21,30,31,40,41; done high for one cycle immediately after the addr-7 write; busy falls the cycle after done.
- Stalled source: pix_valid drops for 3 cycles after the first pair -> mem_we low and mem_addr held at 1 during the gap; the next pair is written at addr 2,3; done fires after addr 7.
- Ready gating: pix_valid held 1 throughout -> pix_ready=0 in every WR1 cycle and in the WR2 cycle of the last pair (addr 7); exactly 4 pairs captured, no fifth capture.
- Start handling: start pulsed during the frame and in the FIN cycle -> no restart and addresses unaffected; start one cycle after returning to IDLE -> new frame begins at addr 0.
- Reset mid-frame: rst_n=0 asynchronously during the addr-3 write -> outputs 0 before the next clock edge; after release, start plus 4 pairs -> clean writes at addr 0..7.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image-pipeline memory reader/writer blocks.
package img_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WR1    = 3'd2,
        WR2    = 3'd3,
        FIN    = 3'd4
    } state_t;

    function automatic int frame_pix(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

endpackage

// File: rtl/frame_buffer_writer.sv
// Captures pixel pairs over valid/ready and serialises them into single-port
// memory writes at raster addresses 0..IMG_W*IMG_H-1, one frame per start.
module frame_buffer_writer
    import img_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pix_in1,
    input  logic [DATA_W-1:0] pix_in2,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
);

    localparam int FRAME_PIX = frame_pix(IMG_W, IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [DATA_W-1:0] pair_2;
    logic              transfer;
    logic              last_written;

    assign transfer     = pix_valid && pix_ready;
    assign last_written = (state == WR2) && (mem_addr == LAST_ADDR);

    // mem_wdata itself serves as the first pair register: pix_in1 is loaded
    // straight into it on capture so the even write appears the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            pair_2    <= '0;
            pix_ready <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ACCEPT;
                        addr_cnt  <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ACCEPT, WR2: begin
                    if (last_written) begin
                        state     <= FIN;
                        mem_we    <= 1'b0;
                        pix_ready <= 1'b0;
                        done      <= 1'b1;
                    end else if (transfer) begin
                        state     <= WR1;
                        pair_2    <= pix_in2;
                        mem_wdata <= pix_in1;
                        mem_addr  <= addr_cnt;
                        addr_cnt  <= addr_cnt + ADDR_W'(1);
                        mem_we    <= 1'b1;
                        pix_ready <= 1'b0;
                    end else if (state == WR2) begin
                        state  <= ACCEPT;
                        mem_we <= 1'b0;
                    end
                end
                WR1: begin
                    state     <= WR2;
                    mem_addr  <= addr_cnt;
                    mem_wdata <= pair_2;
                    // Hold the counter on the final address so it never wraps.
                    if (addr_cnt != LAST_ADDR) begin
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                    end
                    pix_ready <= (addr_cnt != LAST_ADDR);
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_we    <= 1'b0;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer with a 4x2 frame (8 pixels).
module tb_frame_buffer_writer;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [DATA_W-1:0] pix_in1;
    logic [DATA_W-1:0] pix_in2;
    logic              pix_valid;
    logic              pix_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    frame_buffer_writer #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pix_in1  (pix_in1),
        .pix_in2  (pix_in2),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input int addr, input int data, input logic rdy);
        chk({tag, " we"},    32'(mem_we),    32'd1);
        chk({tag, " addr"},  32'(mem_addr),  32'(addr));
        chk({tag, " data"},  32'(mem_wdata), 32'(data));
        chk({tag, " ready"}, 32'(pix_ready), 32'(rdy));
    endtask

    // Full back-to-back frame from IDLE with valid held high throughout.
    task automatic run_frame(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " accept ready"}, 32'(pix_ready), 32'd1);
        chk({tag, " accept busy"},  32'(busy),      32'd1);
        chk({tag, " accept we"},    32'(mem_we),    32'd0);
        pix_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pix_in1 = 8'(16 * (k + 1));
            pix_in2 = 8'(16 * (k + 1) + 1);
            tick();
            chk_write({tag, " wr1"}, 2 * k, 16 * (k + 1), 1'b0);
            pix_in1 = 8'hEE;
            pix_in2 = 8'hEF;
            tick();
            chk_write({tag, " wr2"}, 2 * k + 1, 16 * (k + 1) + 1, (k != 3));
        end
        tick();
        chk({tag, " fin done"}, 32'(done),     32'd1);
        chk({tag, " fin busy"}, 32'(busy),     32'd1);
        chk({tag, " fin we"},   32'(mem_we),   32'd0);
        chk({tag, " fin addr"}, 32'(mem_addr), 32'd7);
        tick();
        chk({tag, " idle done"},  32'(done),      32'd0);
        chk({tag, " idle busy"},  32'(busy),      32'd0);
        chk({tag, " idle ready"}, 32'(pix_ready), 32'd0);
        tick();
        chk({tag, " no 5th capture"}, 32'(mem_we), 32'd0);
        pix_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_in1   = '0;
        pix_in2   = '0;
        pix_valid = 1'b0;

        // Reset with random inputs toggling
        for (int i = 0; i < 3; i++) begin
            start     = 1'($urandom);
            pix_valid = 1'($urandom);
            pix_in1   = 8'($urandom);
            pix_in2   = 8'($urandom);
            tick();
        end
        chk("rst ready", 32'(pix_ready), 32'd0);
        chk("rst we",    32'(mem_we),    32'd0);
        chk("rst addr",  32'(mem_addr),  32'd0);
        chk("rst wdata", 32'(mem_wdata), 32'd0);
        chk("rst busy",  32'(busy),      32'd0);
        chk("rst done",  32'(done),      32'd0);
        start     = 1'b0;
        pix_valid = 1'b1;
        rst_n     = 1'b1;
        tick();
        tick();
        chk("post-rst busy",  32'(busy),      32'd0);
        chk("post-rst ready", 32'(pix_ready), 32'd0);
        chk("post-rst we",    32'(mem_we),    32'd0);
        pix_valid = 1'b0;

        // Back-to-back frame, also covers ready gating
        run_frame("b2b");

        // Stalled source plus start pulses during the frame and in FIN
        start = 1'b1;
        tick();
        start     = 1'b0;
        pix_valid = 1'b1;
        pix_in1   = 8'h10;
        pix_in2   = 8'h11;
        tick();
        chk_write("stall wr1", 0, 8'h10, 1'b0);
        pix_valid = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk_write("stall wr2", 1, 8'h11, 1'b1);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("gap we",    32'(mem_we),    32'd0);
            chk("gap addr",  32'(mem_addr),  32'd1);
            chk("gap data",  32'(mem_wdata), 32'h11);
            chk("gap ready", 32'(pix_ready), 32'd1);
            chk("gap busy",  32'(busy),      32'd1);
        end
        pix_valid = 1'b1;
        for (int k = 1; k < 4; k++) begin
            pix_in1 = 8'(16 * (k + 1));
            pix_in2 = 8'(16 * (k + 1) + 1);
            tick();
            chk_write("stall wr1", 2 * k, 16 * (k + 1), 1'b0);
            if (k == 2) start = 1'b1;
            tick();
            start = 1'b0;
            chk_write("stall wr2", 2 * k + 1, 16 * (k + 1) + 1, (k != 3));
        end
        pix_valid = 1'b0;
        tick();
        chk("stall fin done", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start in fin ignored busy",  32'(busy),      32'd0);
        chk("start in fin ignored ready", 32'(pix_ready), 32'd0);
        chk("start in fin done low",      32'(done),      32'd0);
        tick();
        chk("idle stays idle", 32'(busy), 32'd0);

        // New frame from IDLE, then reset during the addr-3 write
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart busy", 32'(busy), 32'd1);
        pix_valid = 1'b1;
        pix_in1   = 8'hA0;
        pix_in2   = 8'hA1;
        tick();
        chk_write("restart wr1", 0, 8'hA0, 1'b0);
        pix_in1 = 8'hB0;
        pix_in2 = 8'hB1;
        tick();
        chk_write("restart wr2", 1, 8'hA1, 1'b1);
        tick();
        chk_write("restart wr1b", 2, 8'hB0, 1'b0);
        tick();
        chk_write("restart wr2b", 3, 8'hB1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst we",    32'(mem_we),    32'd0);
        chk("async rst addr",  32'(mem_addr),  32'd0);
        chk("async rst wdata", 32'(mem_wdata), 32'd0);
        chk("async rst ready", 32'(pix_ready), 32'd0);
        chk("async rst busy",  32'(busy),      32'd0);
        chk("async rst done",  32'(done),      32'd0);
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after rst idle", 32'(busy), 32'd0);
        run_frame("post-rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
